c2f: RTL and testbench
======================

# c2f

Core-to-Fabric request buffer of the LOTR ring controller. It accepts read, write and broadcast-write requests issued by the local core and queues them in a small entry buffer. It launches each request onto the ring when the ring-output arbiter grants it, and holds each read entry until the matching RD_RSP returns from the ring. The read data is then handed back to the core. It is the initiator-side counterpart of the fabric-to-core receive path inside the same ring controller.

## Interface
- C2F_ENTRIESNUM, 4: buffer depth. Legal range is 1..4, because the entry index is carried in requestor[1:0].
- QClk  in  1  single clock; all state updates on rising edge
- RstQnnnH  in  1  reset, synchronous, active-high
- CoreID  in  8  this core's ring ID
- SelRingReqOutQ501H  in  t_winner  ring-output arbiter winner; C2F_REQUEST = grant to this block
- C2F_ReqValidQ500H / C2F_ReqOpcodeQ500H / C2F_ReqAddressQ500H / C2F_ReqDataQ500H  in  1/t_opcode/32/32  core request (RD, WR, WR_BCAST)
- C2F_FullQ500H  out  1  no FREE entry; core must hold its request
- C2F_ReqValidQ501H / C2F_ReqRequestorQ501H / C2F_ReqOpcodeQ501H / C2F_ReqAddressQ501H / C2F_ReqDataQ501H  out  1/10/t_opcode/32/32  request presented to ring
- RingRspInValidQ501H / RingRspInRequestorQ501H / RingRspInOpcodeQ501H / RingRspInAddressQ501H / RingRspInDataQ501H  in  1/10/t_opcode/32/32  ring response input
- C2F_MatchIdQ501H  out  1  ring response is addressed to this core (consumed, removed from ring)
- C2F_RspValidQ502H / C2F_RspAddressQ502H / C2F_RspDataQ502H  out  1/32/32  read data returned to core

## Operation
- Per-entry state uses t_state: FREE, WRITE, READ, READ_PRGRS, READ_RDY.
- Allocation: on C2F_ReqValidQ500H && !C2F_FullQ500H, the lowest-index FREE entry captures opcode, address and data.
  - RD → READ; WR or WR_BCAST → WRITE (the opcode is kept per entry so WR_BCAST is preserved).
  - A request issued while full is ignored: no state change.
- Ring issue: select the oldest entry in READ or WRITE.
  - Outputs: ReqValid=1, requestor={CoreID, idx[1:0]}, the stored opcode/address/data.
  - If SelRingReqOutQ501H==C2F_REQUEST: WRITE → FREE (posted) and READ → READ_PRGRS.
  - With no grant, the entry holds and the outputs stay stable.
- Response match: C2F_MatchIdQ501H = RingRspInValid && opcode==RD_RSP && requestor[9:2]==CoreID.
  - If additionally entry requestor[1:0] is in READ_PRGRS and the address equals the stored address: capture data, entry → READ_RDY.
  - A matching ID with an entry not in READ_PRGRS, or with an address mismatch, is consumed and dropped with no state change.
- Core return: the oldest READ_RDY entry drives RspValid/Address/Data. The core always accepts, so the entry goes READ_RDY → FREE at the edge.
- Reset: all entries FREE; outstanding reads are discarded.
  - All valid outputs are 0, C2F_FullQ500H=0, ReqOpcode=RD, and address/data/requestor outputs are 0.
  - Data registers need no reset.

## Timing
- Request accepted at edge N (Q500H) → earliest ReqValidQ501H in cycle N+1.
- A grant in cycle M frees a WRITE entry at edge M; that entry is allocatable from cycle M+1, never in the same cycle it frees.
- RD_RSP matched in cycle K → C2F_RspValidQ502H high in cycle K+1 for exactly one cycle per entry.
- Full is combinational from current state only; a same-cycle free does not clear Full.
- A grant and a response for different entries in the same cycle are both applied.
- A response can only match READ_PRGRS, so a grant and a match never hit the same entry.
- Age order comes from the allocation order. Mask0 = READ_RDY (core return) and Mask1 = READ|WRITE (ring issue); dealloc is asserted when the next state is FREE.

## Structure
- lotr_pkg: t_state, t_opcode, t_winner (add C2F_REQUEST if absent), C2F_ENTRIESNUM, C2F_MSB, C2F_ENC_MSB.
- Flops: LOTR_RST_VAL_MSFF for state (reset FREE), LOTR_EN_MSFF for address/data/opcode.
- Use FIND_FIRST for the free-entry select and ONE_HOT_TO_ENC for the read muxes.
- Sub-module: instantiate the existing mro (MRO_MSB=C2F_MSB) for oldest-selection.

## Test plan
- Reset: assert RstQnnnH two cycles mid-traffic → all valids 0, Full 0, next RD lands in entry 0.
- Posted write: CoreID=8'h02, WR addr 32'h0300_0010 data 32'hCAFE, grant in next cycle → ring out opcode WR, requestor 10'h008, entry FREE one cycle later.
- Read round trip: RD addr 32'h0100_0004, grant, then RD_RSP requestor 10'h008 data 32'h1234 → MatchId=1, RspValidQ502H=1 next cycle with data 32'h1234.
- Full: 4 RDs without grants → Full=1; a 5th request is ignored; after one grant plus a matching response, Full stays 1 until READ_RDY is returned, then drops.
- Ordering: WR then RD, with grant withheld 3 cycles → ring issues the WR first, then the RD.
- Stray response: RD_RSP with requestor {CoreID, 2'd3} while entry 3 is FREE → MatchId=1, no RspValid, no state change.

Source files
------------

// File: rtl/lotr_pkg.sv
// LOTR ring controller shared types and helpers.
// Opcodes, arbiter winners, entry states and small select functions.
package lotr_pkg;

  localparam int C2F_ENTRIESNUM = 4;
  localparam int C2F_MSB = C2F_ENTRIESNUM - 1;
  localparam int C2F_ENC_MSB = 1;

  typedef enum logic [2:0] {
    FREE,
    WRITE,
    READ,
    READ_PRGRS,
    READ_RDY
  } t_state;

  typedef enum logic [1:0] {
    RD,
    RD_RSP,
    WR,
    WR_BCAST
  } t_opcode;

  typedef enum logic [1:0] {
    WIN_NONE,
    F2C_RESPONSE,
    BYPASS,
    C2F_REQUEST
  } t_winner;

  function automatic logic [C2F_MSB:0] find_first(
    input logic [C2F_MSB:0] v
  );
    return v & (-v);
  endfunction

  function automatic logic [C2F_ENC_MSB:0] one_hot_to_enc(
    input logic [C2F_MSB:0] oh
  );
    logic [C2F_ENC_MSB:0] e;
    e = '0;
    for (int i = 0; i <= C2F_MSB; i++) begin
      if (oh[i]) e |= (C2F_ENC_MSB + 1)'(i);
    end
    return e;
  endfunction

endpackage

// File: rtl/mro.sv
// Age matrix picking the oldest entry under two request masks.
// older_q[j][i] set means entry j was allocated before entry i.
module mro #(
  parameter int MRO_MSB = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [MRO_MSB:0] alloc,
  input  logic [MRO_MSB:0] dealloc,
  input  logic [MRO_MSB:0] mask0,
  input  logic [MRO_MSB:0] mask1,
  output logic [MRO_MSB:0] first0,
  output logic [MRO_MSB:0] first1
);

  logic [MRO_MSB:0] older_q [MRO_MSB+1];
  logic [MRO_MSB:0] older_d [MRO_MSB+1];

  always_comb begin
    older_d = older_q;
    for (int i = 0; i <= MRO_MSB; i++) begin
      if (dealloc[i]) older_d[i] = '0;
    end
    for (int i = 0; i <= MRO_MSB; i++) begin
      if (alloc[i]) begin
        older_d[i] = '0;
        for (int j = 0; j <= MRO_MSB; j++) begin
          if (j != i) older_d[j][i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= MRO_MSB; i++) older_q[i] <= '0;
    end else begin
      older_q <= older_d;
    end
  end

  always_comb begin
    first0 = mask0;
    first1 = mask1;
    for (int i = 0; i <= MRO_MSB; i++) begin
      for (int j = 0; j <= MRO_MSB; j++) begin
        if (j != i && older_q[j][i]) begin
          if (mask0[j]) first0[i] = 1'b0;
          if (mask1[j]) first1[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/c2f.sv
// Core-to-fabric request buffer: queues core requests, issues them
// to the ring on grant and returns matching read data to the core.
module c2f
  import lotr_pkg::*;
(
  input  logic        QClk,
  input  logic        RstQnnnH,
  input  logic [7:0]  CoreID,
  input  t_winner     SelRingReqOutQ501H,
  input  logic        C2F_ReqValidQ500H,
  input  t_opcode     C2F_ReqOpcodeQ500H,
  input  logic [31:0] C2F_ReqAddressQ500H,
  input  logic [31:0] C2F_ReqDataQ500H,
  output logic        C2F_FullQ500H,
  output logic        C2F_ReqValidQ501H,
  output logic [9:0]  C2F_ReqRequestorQ501H,
  output t_opcode     C2F_ReqOpcodeQ501H,
  output logic [31:0] C2F_ReqAddressQ501H,
  output logic [31:0] C2F_ReqDataQ501H,
  input  logic        RingRspInValidQ501H,
  input  logic [9:0]  RingRspInRequestorQ501H,
  input  t_opcode     RingRspInOpcodeQ501H,
  input  logic [31:0] RingRspInAddressQ501H,
  input  logic [31:0] RingRspInDataQ501H,
  output logic        C2F_MatchIdQ501H,
  output logic        C2F_RspValidQ502H,
  output logic [31:0] C2F_RspAddressQ502H,
  output logic [31:0] C2F_RspDataQ502H
);

  t_state      state_q [C2F_ENTRIESNUM];
  t_state      state_d [C2F_ENTRIESNUM];
  t_opcode     opc_q   [C2F_ENTRIESNUM];
  t_opcode     opc_d   [C2F_ENTRIESNUM];
  logic [31:0] addr_q  [C2F_ENTRIESNUM];
  logic [31:0] addr_d  [C2F_ENTRIESNUM];
  logic [31:0] data_q  [C2F_ENTRIESNUM];
  logic [31:0] data_d  [C2F_ENTRIESNUM];

  logic [C2F_MSB:0] free_vec;
  logic [C2F_MSB:0] alloc_oh;
  logic [C2F_MSB:0] dealloc;
  logic [C2F_MSB:0] mask0;
  logic [C2F_MSB:0] mask1;
  logic [C2F_MSB:0] ret_oh;
  logic [C2F_MSB:0] issue_oh;
  logic [C2F_MSB:0] rsp_hit;
  logic [C2F_ENC_MSB:0] issue_idx;
  logic [C2F_ENC_MSB:0] ret_idx;
  logic issue_vld;
  logic ret_vld;
  logic grant;

  always_comb begin
    for (int i = 0; i <= C2F_MSB; i++) begin
      free_vec[i] = (state_q[i] == FREE);
      mask0[i] = (state_q[i] == READ_RDY);
      mask1[i] = (state_q[i] == READ) ||
                 (state_q[i] == WRITE);
    end
  end

  assign C2F_FullQ500H = ~|free_vec;
  assign alloc_oh = find_first(free_vec) &
    {C2F_ENTRIESNUM{C2F_ReqValidQ500H & ~C2F_FullQ500H}};

  mro #(
    .MRO_MSB (C2F_MSB)
  ) u_mro (
    .clk     (QClk),
    .rst     (RstQnnnH),
    .alloc   (alloc_oh),
    .dealloc (dealloc),
    .mask0   (mask0),
    .mask1   (mask1),
    .first0  (ret_oh),
    .first1  (issue_oh)
  );

  assign issue_vld = |issue_oh;
  assign ret_vld   = |ret_oh;
  assign issue_idx = one_hot_to_enc(issue_oh);
  assign ret_idx   = one_hot_to_enc(ret_oh);
  assign grant = issue_vld &&
                 (SelRingReqOutQ501H == C2F_REQUEST);

  always_comb begin
    C2F_ReqValidQ501H     = issue_vld;
    C2F_ReqRequestorQ501H = '0;
    C2F_ReqOpcodeQ501H    = RD;
    C2F_ReqAddressQ501H   = '0;
    C2F_ReqDataQ501H      = '0;
    if (issue_vld) begin
      C2F_ReqRequestorQ501H = {CoreID, issue_idx};
      C2F_ReqOpcodeQ501H    = opc_q[issue_idx];
      C2F_ReqAddressQ501H   = addr_q[issue_idx];
      C2F_ReqDataQ501H      = data_q[issue_idx];
    end
  end

  always_comb begin
    C2F_RspValidQ502H   = ret_vld;
    C2F_RspAddressQ502H = '0;
    C2F_RspDataQ502H    = '0;
    if (ret_vld) begin
      C2F_RspAddressQ502H = addr_q[ret_idx];
      C2F_RspDataQ502H    = data_q[ret_idx];
    end
  end

  assign C2F_MatchIdQ501H = RingRspInValidQ501H &&
    (RingRspInOpcodeQ501H == RD_RSP) &&
    (RingRspInRequestorQ501H[9:2] == CoreID);

  // Only an in-flight read with the same address takes the data.
  always_comb begin
    for (int i = 0; i <= C2F_MSB; i++) begin
      rsp_hit[i] = C2F_MatchIdQ501H &&
        (RingRspInRequestorQ501H[1:0] == 2'(i)) &&
        (state_q[i] == READ_PRGRS) &&
        (RingRspInAddressQ501H == addr_q[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    addr_d  = addr_q;
    data_d  = data_q;
    for (int i = 0; i <= C2F_MSB; i++) begin
      if (alloc_oh[i]) begin
        state_d[i] = (C2F_ReqOpcodeQ500H == RD) ? READ : WRITE;
        opc_d[i]   = C2F_ReqOpcodeQ500H;
        addr_d[i]  = C2F_ReqAddressQ500H;
        data_d[i]  = C2F_ReqDataQ500H;
      end
      if (grant && issue_oh[i]) begin
        state_d[i] = (state_q[i] == WRITE) ? FREE : READ_PRGRS;
      end
      if (rsp_hit[i]) begin
        state_d[i] = READ_RDY;
        data_d[i]  = RingRspInDataQ501H;
      end
      if (ret_oh[i]) state_d[i] = FREE;
    end
  end

  always_comb begin
    for (int i = 0; i <= C2F_MSB; i++) begin
      dealloc[i] = (state_q[i] != FREE) && (state_d[i] == FREE);
    end
  end

  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      for (int i = 0; i <= C2F_MSB; i++) state_q[i] <= FREE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge QClk) begin
    opc_q  <= opc_d;
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_c2f.sv
// Directed bench for the c2f request buffer.
module tb_c2f;
  import lotr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  core_id;
  t_winner     sel;
  logic        req_v;
  t_opcode     req_op;
  logic [31:0] req_a;
  logic [31:0] req_d;
  logic        full;
  logic        out_v;
  logic [9:0]  out_r;
  t_opcode     out_op;
  logic [31:0] out_a;
  logic [31:0] out_d;
  logic        rin_v;
  logic [9:0]  rin_r;
  t_opcode     rin_op;
  logic [31:0] rin_a;
  logic [31:0] rin_d;
  logic        match;
  logic        rsp_v;
  logic [31:0] rsp_a;
  logic [31:0] rsp_d;

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  c2f dut (
    .QClk                    (clk),
    .RstQnnnH                (rst),
    .CoreID                  (core_id),
    .SelRingReqOutQ501H      (sel),
    .C2F_ReqValidQ500H       (req_v),
    .C2F_ReqOpcodeQ500H      (req_op),
    .C2F_ReqAddressQ500H     (req_a),
    .C2F_ReqDataQ500H        (req_d),
    .C2F_FullQ500H           (full),
    .C2F_ReqValidQ501H       (out_v),
    .C2F_ReqRequestorQ501H   (out_r),
    .C2F_ReqOpcodeQ501H      (out_op),
    .C2F_ReqAddressQ501H     (out_a),
    .C2F_ReqDataQ501H        (out_d),
    .RingRspInValidQ501H     (rin_v),
    .RingRspInRequestorQ501H (rin_r),
    .RingRspInOpcodeQ501H    (rin_op),
    .RingRspInAddressQ501H   (rin_a),
    .RingRspInDataQ501H      (rin_d),
    .C2F_MatchIdQ501H        (match),
    .C2F_RspValidQ502H       (rsp_v),
    .C2F_RspAddressQ502H     (rsp_a),
    .C2F_RspDataQ502H        (rsp_d)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input t_opcode op,
                         input logic [31:0] a, input logic [31:0] d);
    req_v = v; req_op = op; req_a = a; req_d = d;
    #1;
  endtask

  task automatic set_rsp(input logic v, input logic [9:0] r,
                         input logic [31:0] a, input logic [31:0] d);
    rin_v = v; rin_r = r; rin_op = RD_RSP; rin_a = a; rin_d = d;
    #1;
  endtask

  task automatic set_sel(input t_winner w);
    sel = w;
    #1;
  endtask

  initial begin
    rst = 1'b1; core_id = 8'h02; sel = WIN_NONE;
    req_v = 0; req_op = RD; req_a = '0; req_d = '0;
    rin_v = 0; rin_r = '0; rin_op = RD; rin_a = '0; rin_d = '0;
    tick; tick;
    rst = 1'b0;
    #1;
    chk("rst_reqv", 64'(out_v), 64'h0);
    chk("rst_full", 64'(full), 64'h0);
    chk("rst_rspv", 64'(rsp_v), 64'h0);
    chk("rst_match", 64'(match), 64'h0);
    chk("rst_op", 64'(out_op), 64'(RD));
    chk("rst_addr", 64'(out_a), 64'h0);
    chk("rst_reqr", 64'(out_r), 64'h0);

    // posted write
    set_req(1, WR, 32'h0300_0010, 32'hCAFE);
    tick;
    set_req(0, RD, '0, '0);
    set_sel(C2F_REQUEST);
    chk("wr_v", 64'(out_v), 64'h1);
    chk("wr_op", 64'(out_op), 64'(WR));
    chk("wr_req", 64'(out_r), 64'h008);
    chk("wr_addr", 64'(out_a), 64'h0300_0010);
    chk("wr_data", 64'(out_d), 64'hCAFE);
    tick;
    set_sel(WIN_NONE);
    chk("wr_freed_v", 64'(out_v), 64'h0);
    chk("wr_freed_full", 64'(full), 64'h0);

    // read round trip
    set_req(1, RD, 32'h0100_0004, 32'h0);
    tick;
    set_req(0, RD, '0, '0);
    chk("rd_v", 64'(out_v), 64'h1);
    chk("rd_op", 64'(out_op), 64'(RD));
    chk("rd_req", 64'(out_r), 64'h008);
    set_sel(C2F_REQUEST);
    tick;
    set_sel(WIN_NONE);
    chk("rd_issued", 64'(out_v), 64'h0);
    set_rsp(1, 10'h008, 32'h0100_0004, 32'h1234);
    chk("rd_match", 64'(match), 64'h1);
    chk("rd_rsp_early", 64'(rsp_v), 64'h0);
    tick;
    set_rsp(0, '0, '0, '0);
    chk("rd_rspv", 64'(rsp_v), 64'h1);
    chk("rd_rspd", 64'(rsp_d), 64'h1234);
    chk("rd_rspa", 64'(rsp_a), 64'h0100_0004);
    tick;
    chk("rd_rsp_once", 64'(rsp_v), 64'h0);

    // stray response and foreign core id
    set_rsp(1, 10'h00B, 32'h0100_0004, 32'h5555);
    chk("stray_match", 64'(match), 64'h1);
    tick;
    set_rsp(1, 10'h018, 32'h0, 32'h0);
    chk("foreign_match", 64'(match), 64'h0);
    chk("stray_rspv", 64'(rsp_v), 64'h0);
    chk("stray_reqv", 64'(out_v), 64'h0);
    chk("stray_full", 64'(full), 64'h0);
    set_rsp(0, '0, '0, '0);

    // ordering: WR then RD, grant withheld
    set_req(1, WR, 32'h10, 32'h77);
    tick;
    set_req(1, RD, 32'h20, 32'h0);
    tick;
    set_req(0, RD, '0, '0);
    for (int c = 0; c < 3; c++) begin
      chk("ord_hold_op", 64'(out_op), 64'(WR));
      chk("ord_hold_req", 64'(out_r), 64'h008);
      tick;
    end
    set_sel(C2F_REQUEST);
    chk("ord_first", 64'(out_op), 64'(WR));
    tick;
    chk("ord_second_op", 64'(out_op), 64'(RD));
    chk("ord_second_req", 64'(out_r), 64'h009);
    chk("ord_second_a", 64'(out_a), 64'h20);
    tick;
    set_sel(WIN_NONE);
    chk("ord_done", 64'(out_v), 64'h0);
    set_rsp(1, 10'h009, 32'h20, 32'h99);
    tick;
    set_rsp(0, '0, '0, '0);
    chk("ord_rspd", 64'(rsp_d), 64'h99);
    tick;

    // full
    for (int i = 0; i < 4; i++) begin
      chk("fill_notfull", 64'(full), 64'h0);
      set_req(1, RD, 32'h100 + 32'(i) * 4, 32'h0);
      tick;
    end
    chk("full_set", 64'(full), 64'h1);
    set_req(1, RD, 32'hDEAD, 32'h0);
    tick;
    set_req(0, RD, '0, '0);
    chk("full_hold", 64'(full), 64'h1);
    chk("full_oldest_a", 64'(out_a), 64'h100);
    chk("full_oldest_r", 64'(out_r), 64'h008);
    set_sel(C2F_REQUEST);
    tick;
    set_sel(WIN_NONE);
    chk("full_next_r", 64'(out_r), 64'h009);
    chk("full_after_grant", 64'(full), 64'h1);
    set_rsp(1, 10'h008, 32'h100, 32'h55);
    chk("full_at_match", 64'(full), 64'h1);
    tick;
    set_rsp(0, '0, '0, '0);
    chk("full_rdy", 64'(full), 64'h1);
    chk("full_rspd", 64'(rsp_d), 64'h55);
    tick;
    chk("full_drop", 64'(full), 64'h0);
    chk("full_rsp_off", 64'(rsp_v), 64'h0);
    set_sel(C2F_REQUEST);
    chk("drain_r1", 64'(out_r), 64'h009);
    tick;
    chk("drain_r2", 64'(out_r), 64'h00A);
    tick;
    chk("drain_r3", 64'(out_r), 64'h00B);
    chk("drain_a3", 64'(out_a), 64'h10C);
    tick;
    set_sel(WIN_NONE);
    chk("fifth_ignored", 64'(out_v), 64'h0);

    // reset mid-traffic with all entries busy
    set_req(1, WR, 32'h44, 32'h66);
    tick;
    set_req(0, RD, '0, '0);
    chk("pre_rst_full", 64'(full), 64'h1);
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    #1;
    chk("mid_rst_full", 64'(full), 64'h0);
    chk("mid_rst_reqv", 64'(out_v), 64'h0);
    chk("mid_rst_rspv", 64'(rsp_v), 64'h0);
    set_req(1, RD, 32'h0200_0000, 32'h0);
    tick;
    set_req(0, RD, '0, '0);
    chk("post_rst_req", 64'(out_r), 64'h008);
    chk("post_rst_a", 64'(out_a), 64'h0200_0000);
    set_rsp(1, 10'h009, 32'h104, 32'h0);
    chk("disc_match", 64'(match), 64'h1);
    tick;
    set_rsp(0, '0, '0, '0);
    chk("disc_rspv", 64'(rsp_v), 64'h0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
